// File: rtl/dual_issue_scoreboard.sv
// rtl/dual_issue_scoreboard.sv - dual-issue scheduler with long-latency busy scoreboard and serial drain FSM
module dual_issue_scoreboard #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               ex_ready_i,
  input  logic               d1_valid_i,
  input  logic [ADDR_W-1:0]  d1_ra1_i,
  input  logic [ADDR_W-1:0]  d1_ra2_i,
  input  logic               d1_re1_i,
  input  logic               d1_re2_i,
  input  logic [ADDR_W-1:0]  d1_wa_i,
  input  logic               d1_we_i,
  input  logic               d1_long_i,
  input  logic               d1_serial_i,
  input  logic               d2_valid_i,
  input  logic [ADDR_W-1:0]  d2_ra1_i,
  input  logic [ADDR_W-1:0]  d2_ra2_i,
  input  logic               d2_re1_i,
  input  logic               d2_re2_i,
  input  logic [ADDR_W-1:0]  d2_wa_i,
  input  logic               d2_we_i,
  input  logic               d2_long_i,
  input  logic               d2_serial_i,
  input  logic               cmp_valid_i,
  input  logic [ADDR_W-1:0]  cmp_wa_i,
  output logic               iss1_o,
  output logic               iss2_o,
  output logic               stall_o,
  output logic [REG_NUM-1:0] busy_o,
  output logic               drain_o
);

  typedef enum logic {S_RUN = 1'b0, S_DRAIN = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [REG_NUM-1:0] busy_q, busy_d;
  logic               d1_ok, d2_ok, raw12, waw12, iss1, iss2;

  // A register access conflicts with the scoreboard only for non-zero enabled addresses.
  function automatic logic hit(input logic en, input logic [ADDR_W-1:0] a,
                               input logic [REG_NUM-1:0] b);
    return en && (a != '0) && b[a];
  endfunction

  always_comb begin
    d1_ok = d1_valid_i && ex_ready_i && !flush_i && (state_q == S_RUN)
         && !hit(d1_re1_i, d1_ra1_i, busy_q) && !hit(d1_re2_i, d1_ra2_i, busy_q)
         && !hit(d1_we_i, d1_wa_i, busy_q)
         && (!d1_serial_i || (busy_q == '0));
    raw12 = d1_we_i && ((d2_re1_i && (d2_ra1_i != '0) && (d2_ra1_i == d1_wa_i))
                     || (d2_re2_i && (d2_ra2_i != '0) && (d2_ra2_i == d1_wa_i)));
    waw12 = d1_we_i && d2_we_i && (d1_wa_i == d2_wa_i) && (d1_wa_i != '0);
    d2_ok = d2_valid_i
         && !hit(d2_re1_i, d2_ra1_i, busy_q) && !hit(d2_re2_i, d2_ra2_i, busy_q)
         && !hit(d2_we_i, d2_wa_i, busy_q)
         && !d1_serial_i && !d2_serial_i && !raw12 && !waw12
         && !(d1_long_i && d2_long_i);
    // Reset is asynchronous, so issue is gated within the cycle it arrives.
    iss1  = !rst_i && d1_ok;
    iss2  = iss1 && d2_ok;
  end

  always_comb begin
    busy_d = busy_q;
    if (cmp_valid_i) busy_d[cmp_wa_i] = 1'b0;
    if (iss1 && d1_long_i && d1_we_i && (d1_wa_i != '0)) busy_d[d1_wa_i] = 1'b1;
    if (iss2 && d2_long_i && d2_we_i && (d2_wa_i != '0)) busy_d[d2_wa_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (iss1 && d1_serial_i) state_d = S_DRAIN;
      S_DRAIN: if ((busy_q == '0) && ex_ready_i) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      state_q <= S_RUN;
    end else begin
      busy_q  <= busy_d;
      state_q <= state_d;
    end
  end

  assign iss1_o  = iss1;
  assign iss2_o  = iss2;
  assign stall_o = !rst_i && d1_valid_i && !iss1;
  assign busy_o  = busy_q;
  assign drain_o = (state_q == S_DRAIN);

endmodule

// File: tb/tb_dual_issue_scoreboard.sv
// tb/tb_dual_issue_scoreboard.sv - table vectors plus multi-cycle sequences for dual_issue_scoreboard
module tb_dual_issue_scoreboard;

  localparam int REG_NUM = 32;
  localparam int ADDR_W  = 5;

  typedef struct packed {
    logic v; logic [4:0] ra1; logic re1; logic [4:0] ra2; logic re2;
    logic [4:0] wa; logic we; logic lng; logic ser;
  } ins_t;

  typedef struct {
    ins_t a; ins_t b; logic exr; logic fl;
    logic e1; logic e2; logic es;
  } vec_t;

  typedef struct { logic i1; logic i2; logic st; } exp_t;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, ex_ready = 1'b1;
  ins_t d1, d2;
  logic cmp_valid = 1'b0;
  logic [ADDR_W-1:0] cmp_wa = '0;
  logic iss1, iss2, stall, drain;
  logic [REG_NUM-1:0] busy;

  int checks = 0, errors = 0;
  string tag = "";
  exp_t exp_q[$];
  vec_t vecs[13];

  dual_issue_scoreboard #(.REG_NUM(REG_NUM), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .ex_ready_i(ex_ready),
    .d1_valid_i(d1.v), .d1_ra1_i(d1.ra1), .d1_ra2_i(d1.ra2), .d1_re1_i(d1.re1),
    .d1_re2_i(d1.re2), .d1_wa_i(d1.wa), .d1_we_i(d1.we), .d1_long_i(d1.lng),
    .d1_serial_i(d1.ser),
    .d2_valid_i(d2.v), .d2_ra1_i(d2.ra1), .d2_ra2_i(d2.ra2), .d2_re1_i(d2.re1),
    .d2_re2_i(d2.re2), .d2_wa_i(d2.wa), .d2_we_i(d2.we), .d2_long_i(d2.lng),
    .d2_serial_i(d2.ser),
    .cmp_valid_i(cmp_valid), .cmp_wa_i(cmp_wa),
    .iss1_o(iss1), .iss2_o(iss2), .stall_o(stall), .busy_o(busy), .drain_o(drain)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic ins_t mk(input logic v, input logic [4:0] ra1, input logic re1,
                              input logic [4:0] ra2, input logic re2, input logic [4:0] wa,
                              input logic we, input logic lng, input logic ser);
    ins_t r;
    r.v = v; r.ra1 = ra1; r.re1 = re1; r.ra2 = ra2; r.re2 = re2;
    r.wa = wa; r.we = we; r.lng = lng; r.ser = ser;
    return r;
  endfunction

  function automatic ins_t add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return mk(1'b1, rs, 1'b1, rt, 1'b1, rd, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic ins_t nop_slot();
    return mk(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s act=%h exp=%h", tag, name, act, exp);
    end
  endtask

  task automatic step(input string t, input logic e1, input logic e2, input logic es);
    exp_t e;
    tag = t;
    e.i1 = e1; e.i2 = e2; e.st = es;
    exp_q.push_back(e);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s/queue act=empty exp=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk("iss1", {31'd0, iss1}, {31'd0, e.i1});
      chk("iss2", {31'd0, iss2}, {31'd0, e.i2});
      chk("stall", {31'd0, stall}, {31'd0, e.st});
    end
  endtask

  task automatic idle();
    d1 = nop_slot(); d2 = nop_slot();
    flush = 1'b0; ex_ready = 1'b1; cmp_valid = 1'b0; cmp_wa = '0;
  endtask

  initial begin
    // d1, d2, ex_ready, flush, iss1, iss2, stall
    vecs[0]  = '{add(3,1,2), add(4,5,6), 1, 0, 1, 1, 0};
    vecs[1]  = '{add(7,1,2), add(4,7,6), 1, 0, 1, 0, 0};
    vecs[2]  = '{add(7,1,2), mk(1,7,0,6,1,4,1,0,0), 1, 0, 1, 1, 0};
    vecs[3]  = '{add(9,1,2), add(9,5,6), 1, 0, 1, 0, 0};
    vecs[4]  = '{add(0,1,2), add(0,5,6), 1, 0, 1, 1, 0};
    vecs[5]  = '{mk(1,1,1,0,0,0,0,1,0), mk(1,2,1,0,0,0,0,1,0), 1, 0, 1, 0, 0};
    vecs[6]  = '{add(3,1,2), add(4,5,6), 1, 1, 0, 0, 1};
    vecs[7]  = '{add(3,1,2), add(4,5,6), 0, 0, 0, 0, 1};
    vecs[8]  = '{nop_slot(), add(4,5,6), 1, 0, 0, 0, 0};
    vecs[9]  = '{add(3,1,2), nop_slot(), 1, 0, 1, 0, 0};
    vecs[10] = '{add(3,1,2), mk(1,0,0,0,0,0,0,0,1), 1, 0, 1, 0, 0};
    vecs[11] = '{mk(1,1,1,2,1,7,0,0,0), add(4,7,6), 1, 0, 1, 1, 0};
    vecs[12] = '{add(0,1,2), add(4,0,0), 1, 0, 1, 1, 0};

    idle();
    rst = 1'b1;
    d1 = add(3, 1, 2);
    #12;
    step("reset", 0, 0, 0);
    chk("busy", busy, 32'd0);
    chk("drain", {31'd0, drain}, 32'd0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      idle();
      d1 = vecs[i].a; d2 = vecs[i].b; ex_ready = vecs[i].exr; flush = vecs[i].fl;
      step($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2, vecs[i].es);
    end
    @(negedge clk); idle();
    tag = "after_table";
    chk("busy", busy, 32'd0);

    // load r8 in slot 1 and load r12 in slot 2 of separate pairs
    d1 = mk(1, 1, 1, 0, 0, 8, 1, 1, 0);
    step("load8", 1, 0, 0);
    @(negedge clk); idle();
    chk("busy8", busy, 32'h0000_0100);
    d1 = add(3, 1, 2); d2 = mk(1, 1, 1, 0, 0, 12, 1, 1, 0);
    step("load12_slot2", 1, 1, 0);
    @(negedge clk); idle();
    chk("busy8_12", busy, 32'h0000_1100);
    d1 = add(9, 8, 2);
    step("use8", 0, 0, 1);
    @(negedge clk);
    d1 = add(8, 1, 2);
    step("waw8", 0, 0, 1);
    @(negedge clk); idle();
    d1 = add(3, 1, 2); d2 = add(4, 12, 2);
    step("slot2_blocked", 1, 0, 0);
    @(negedge clk); idle();
    cmp_valid = 1'b1; cmp_wa = 5'd0;
    @(negedge clk); cmp_wa = 5'd3;
    @(negedge clk); idle();
    chk("cmp_ignored", busy, 32'h0000_1100);
    d1 = add(9, 8, 2); cmp_valid = 1'b1; cmp_wa = 5'd8;
    step("no_bypass", 0, 0, 1);
    @(negedge clk); cmp_valid = 1'b0;
    chk("cleared8", busy, 32'h0000_1000);
    step("use8_after", 1, 0, 0);
    @(negedge clk); idle();
    cmp_valid = 1'b1; cmp_wa = 5'd12;
    @(negedge clk); idle();
    chk("cleared12", busy, 32'd0);

    // serial drain: busy r4 holds the serial op, younger add waits in DRAIN
    d1 = mk(1, 1, 1, 0, 0, 4, 1, 1, 0);
    step("load4", 1, 0, 0);
    @(negedge clk); idle();
    d1 = mk(1, 0, 0, 0, 0, 0, 0, 0, 1); d2 = add(5, 1, 2);
    step("serial_wait", 0, 0, 1);
    @(negedge clk); cmp_valid = 1'b1; cmp_wa = 5'd4;
    step("serial_wait_cmp", 0, 0, 1);
    @(negedge clk); cmp_valid = 1'b0;
    step("serial_issue", 1, 0, 0);
    @(negedge clk); idle();
    chk("drain_on", {31'd0, drain}, 32'd1);
    d1 = add(5, 1, 2); ex_ready = 1'b0; flush = 1'b1;
    step("drain_hold", 0, 0, 1);
    @(negedge clk); ex_ready = 1'b1; flush = 1'b0;
    chk("drain_kept", {31'd0, drain}, 32'd1);
    step("drain_last", 0, 0, 1);
    @(negedge clk);
    chk("drain_off", {31'd0, drain}, 32'd0);
    step("add_after_drain", 1, 0, 0);

    // asynchronous reset with a load in flight
    @(negedge clk); idle();
    d1 = mk(1, 1, 1, 0, 0, 10, 1, 1, 0);
    step("load10", 1, 0, 0);
    @(negedge clk); idle();
    chk("busy10", busy, 32'h0000_0400);
    d1 = add(11, 10, 0);
    #2 rst = 1'b1;
    step("rst_mid_load", 0, 0, 0);
    chk("rst_busy", busy, 32'd0);
    @(negedge clk); rst = 1'b0;
    step("post_rst_issue", 1, 0, 0);

    // asynchronous reset while draining
    @(negedge clk); idle();
    d1 = mk(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step("serial2", 1, 0, 0);
    @(negedge clk); idle(); ex_ready = 1'b0;
    chk("drain2_on", {31'd0, drain}, 32'd1);
    #2 rst = 1'b1;
    #1;
    tag = "rst_in_drain";
    chk("drain", {31'd0, drain}, 32'd0);
    @(negedge clk); rst = 1'b0; ex_ready = 1'b1;
    d1 = add(3, 1, 2);
    step("run_after_rst", 1, 0, 0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
